led_fade_pwm: RTL and testbench



---
 rtl/led_fade_pwm_pkg.sv | 21 ++
 rtl/led_fade_pwm_fade_channel.sv | 92 +++++++++
 rtl/led_fade_pwm.sv | 104 ++++++++++
 tb/tb_led_fade_pwm.sv | 132 +++++++++++++
 4 files changed

// File: rtl/led_fade_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_pkg
// Shared definitions for the LED fade/PWM stage that sits behind the
// Knight Rider sequencer: channel count, top-level state encoding and the
// full-scale brightness helper.
// ---------------------------------------------------------------------------
package led_fade_pwm_pkg;

  localparam int LED_COUNT = 8;

  typedef enum logic [1:0] {
    ST_BLANK = 2'b00,
    ST_RUN   = 2'b01
  } fade_state_e;

  // Full-scale brightness for a given PWM counter width.
  function automatic int unsigned level_max_f(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_pwm_fade_channel.sv
// ---------------------------------------------------------------------------
// fade_channel
// One LED's brightness path. A lit pattern bit forces full brightness; once
// the bit drops, the level decays by DECAY_STEP on every decay tick and
// saturates at zero. The level is copied into a shadow register at each PWM
// wrap so the duty cycle only changes on a period boundary.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   enable       channel running; 0 clears level, shadow and output
//   pattern_bit  this LED's bit of the sequencer pattern
//   decay_tick   one-cycle strobe: apply one decay step
//   wrap         one-cycle strobe: PWM counter at full scale, load shadow
//   pwm_cnt      shared PWM counter
//   led_out      registered PWM drive for this LED
// ---------------------------------------------------------------------------
module fade_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pattern_bit,
  input  logic                decay_tick,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = PWM_BITS'(level_max_f(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

  // Level minus step, clamped at zero; a negative or zero difference never
  // wraps back to a bright value.
  function automatic logic [PWM_BITS-1:0] sat_sub(
    input logic [PWM_BITS-1:0] level,
    input logic [PWM_BITS-1:0] step
  );
    logic signed [PWM_BITS:0] diff;
    diff = $signed({1'b0, level}) - $signed({1'b0, step});
    if (diff <= 0) begin
      return '0;
    end
    return diff[PWM_BITS-1:0];
  endfunction

  logic [PWM_BITS-1:0] level_q,  level_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                led_q,    led_d;

  // Stage 0: brightness level and period-aligned shadow
  always_comb begin
    level_d  = level_q;
    active_d = active_q;
    if (!enable) begin
      level_d  = '0;
      active_d = '0;
    end else begin
      if (pattern_bit) begin
        level_d = LEVEL_MAX;
      end else if (decay_tick) begin
        level_d = sat_sub(level_q, STEP);
      end
      if (wrap) begin
        active_d = level_q;
      end
    end
  end

  // Stage 1: registered PWM comparator
  always_comb begin
    led_d = enable & ((active_q == LEVEL_MAX) | (pwm_cnt < active_q));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q  <= '0;
      active_q <= '0;
      led_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
// Drives the board LEDs from the sequencer's one-hot pattern with PWM
// brightness: lit LEDs are solid, released LEDs fade out in steps.
// Holds the BLANK/RUN state machine, the shared PWM and decay counters and
// the period_start strobe; one fade_channel per LED does the rest.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   enable        1 = run, 0 = blank LEDs and clear all fade state
//   pattern_in    LED pattern from the sequencer (bit i = LED i lit)
//   leds_out      registered PWM LED drive
//   period_start  one-cycle pulse in the clock where shadow levels load
// ---------------------------------------------------------------------------
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 2**18,
  parameter int DECAY_STEP = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LED_COUNT-1:0] pattern_in,
  output logic [LED_COUNT-1:0] leds_out,
  output logic                 period_start
);

  localparam int                  DECAY_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DECAY_W-1:0]  DECAY_LAST = DECAY_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] LEVEL_MAX  = PWM_BITS'(level_max_f(PWM_BITS));

  fade_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DECAY_W-1:0]  decay_cnt_q, decay_cnt_d;
  logic                period_start_q, period_start_d;
  logic                run;
  logic                wrap;
  logic                decay_tick;

  // Counters only move once the FSM has settled in RUN, so every re-entry
  // starts with both counters at zero and a dark first period.
  assign run        = (state_q == ST_RUN) & enable;
  assign wrap       = run & (pwm_cnt_q == LEVEL_MAX);
  assign decay_tick = run & (decay_cnt_q == DECAY_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (enable)  state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Stage 0: shared timebase
  always_comb begin
    pwm_cnt_d      = '0;
    decay_cnt_d    = '0;
    period_start_d = wrap;
    if (run) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (!decay_tick) begin
        decay_cnt_d = decay_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_BLANK;
      pwm_cnt_q      <= '0;
      decay_cnt_q    <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pwm_cnt_q      <= pwm_cnt_d;
      decay_cnt_q    <= decay_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  // Stage 1: per-LED fade and PWM output
  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    fade_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .enable      (run),
      .pattern_bit (pattern_in[i]),
      .decay_tick  (decay_tick),
      .wrap        (wrap),
      .pwm_cnt     (pwm_cnt_q),
      .led_out     (leds_out[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_fade_pwm
// Directed bench for led_fade_pwm with PWM_BITS=4, DECAY_DIV=4,
// DECAY_STEP=4 (LEVEL_MAX=15). Sample index cyc counts clock edges after
// enable is raised; expected LED bytes per sample are written out as ranges.
// ---------------------------------------------------------------------------
module tb_led_fade_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] pattern_in;
  logic [7:0] leds_out;
  logic       period_start;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  led_fade_pwm #(
    .PWM_BITS   (4),
    .DECAY_DIV  (4),
    .DECAY_STEP (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .pattern_in   (pattern_in),
    .leds_out     (leds_out),
    .period_start (period_start)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hand-derived LED byte after clock edge c of the main run.
  function automatic logic [7:0] exp_leds(input int c);
    if (c <= 17)  return 8'h00;  // dark first period
    if (c <= 56)  return 8'h01;  // solid, then duty 7 period (edges 50..56 high)
    if (c <= 113) return 8'h00;  // faded out, no wrap back up
    if (c <= 129) return 8'h08;  // LED3 solid across decay ticks
    if (c <= 132) return 8'h89;  // LED3 at duty 3, LEDs 7 and 0 solid
    if (c <= 136) return 8'h81;
    if (c <= 157) return 8'h00;  // disabled, then dark first period
    if (c <= 192) return 8'h81;  // solid, then duty 3 starting at 190
    return 8'h00;
  endfunction

  function automatic logic exp_ps(input int c);
    if (c >= 17 && c <= 136 && ((c - 17) % 16) == 0) return 1'b1;
    if (c >= 157 && ((c - 157) % 16) == 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    pattern_in = 8'h00;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check_val("reset_leds", {24'h0, leds_out}, 32'h0);
    check_val("reset_ps", {31'h0, period_start}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_val("blank_leds", {24'h0, leds_out}, 32'h0);

    // Main directed run
    enable     = 1'b1;
    pattern_in = 8'h01;
    cyc        = 0;
    while (cyc < 191) begin
      tick();
      check_val($sformatf("leds@%0d", cyc), {24'h0, leds_out}, {24'h0, exp_leds(cyc)});
      check_val($sformatf("ps@%0d", cyc), {31'h0, period_start}, {31'h0, exp_ps(cyc)});
      if (cyc == 49)  check_val("level0@49", {28'h0, u_dut.g_ch[0].u_ch.level_q}, 32'd3);
      if (cyc == 57)  check_val("level0@57", {28'h0, u_dut.g_ch[0].u_ch.level_q}, 32'd0);
      if (cyc == 101) check_val("level3@101", {28'h0, u_dut.g_ch[3].u_ch.level_q}, 32'd15);
      if (cyc == 137) begin
        check_val("pwm_cnt_off", {28'h0, u_dut.pwm_cnt_q}, 32'd0);
        check_val("decay_cnt_off", {30'h0, u_dut.decay_cnt_q}, 32'd0);
        check_val("level0_off", {28'h0, u_dut.g_ch[0].u_ch.level_q}, 32'd0);
        check_val("level3_off", {28'h0, u_dut.g_ch[3].u_ch.level_q}, 32'd0);
        check_val("level7_off", {28'h0, u_dut.g_ch[7].u_ch.level_q}, 32'd0);
        check_val("active7_off", {28'h0, u_dut.g_ch[7].u_ch.active_q}, 32'd0);
      end
      case (cyc)
        37:  pattern_in = 8'h00;
        97:  pattern_in = 8'h08;
        113: pattern_in = 8'h81;
        136: enable     = 1'b0;
        140: enable     = 1'b1;
        173: pattern_in = 8'h00;
        default: ;
      endcase
    end

    // Asynchronous reset while LEDs are toggling
    #1 rst = 1'b0;
    #1;
    check_val("async_rst_leds", {24'h0, leds_out}, 32'h0);
    check_val("async_rst_ps", {31'h0, period_start}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      tick();
      check_val($sformatf("rst_ps@%0d", cyc), {31'h0, period_start}, {31'h0, (cyc == 17)});
      check_val($sformatf("rst_leds@%0d", cyc), {24'h0, leds_out}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
